// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: opcodes, functs,
// ALU control codes, FSM states and the combinational ALU.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_SLTU = 4'b1000;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXECUTE,
      MEMORY,
      WRITEBACK,
      HALT
   } state_t;

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                        (funct == FN_OR)  || (funct == FN_NOR) || (funct == FN_SLT) ||
                        (funct == FN_SLTU);
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Non-R-type users of the ALU (addi, lw, sw) all need an add.
   function automatic logic [3:0] alu_ctrl(input logic [5:0] op, input logic [5:0] funct);
      logic [3:0] c;
      c = ALU_ADD;
      if (op == OP_RTYPE) begin
         case (funct)
            FN_SUB:  c = ALU_SUB;
            FN_AND:  c = ALU_AND;
            FN_OR:   c = ALU_OR;
            FN_NOR:  c = ALU_NOR;
            FN_SLT:  c = ALU_SLT;
            FN_SLTU: c = ALU_SLTU;
            default: c = ALU_ADD;
         endcase
      end
      return c;
   endfunction

   function automatic logic [31:0] alu(input logic [3:0] ctrl, input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] r;
      r = a + b;
      case (ctrl)
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_SUB:  r = a - b;
         ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
         ALU_SLTU: r = {31'd0, (a < b)};
         ALU_NOR:  r = ~(a | b);
         default:  r = a + b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/regfile_sync.sv
// 32 x 32 register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear; register 0 always reads zero.
module regfile_sync (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] regs [32];

   // NOTE: this array is reset on purpose (architectural state must read zero),
   // which forces flops rather than a RAM macro; non-blocking keeps it race-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs[wa] <= wd;
      end
   end

   // Entry 0 is never written, so it stays at its reset value of zero.
   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core sharing one word memory for fetch and data
// through a strobe/ready handshake.
module multicycle_datapath
   import mips_pkg::*;
#(
   parameter int          ADDR_WIDTH = 7,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [31:0]           memWriteData,
   input  logic [31:0]           memReadData,
   output logic                  memRead,
   output logic                  memWrite,
   input  logic                  memReady,
   output logic [31:0]           pc,
   output logic                  halted
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, ir, a, b, target, aluout, mdr;
   logic [31:0] rd1, rd2, sext_imm, alu_b, alu_res, wd;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wa;
   logic        rf_we;

   assign op       = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign funct    = ir[5:0];
   assign sext_imm = {{16{ir[15]}}, ir[15:0]};

   assign alu_b   = (op == OP_RTYPE) ? b : sext_imm;
   assign alu_res = alu(alu_ctrl(op, funct), a, alu_b);

   assign rf_we = (state_q == WRITEBACK);
   assign wa    = (op == OP_RTYPE) ? rd : rt;
   assign wd    = (op == OP_LW) ? mdr : aluout;

   regfile_sync u_rf (
      .clk   (clk),
      .reset (reset),
      .ra1   (rs),
      .ra2   (rt),
      .rd1   (rd1),
      .rd2   (rd2),
      .we    (rf_we),
      .wa    (wa),
      .wd    (wd)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         ir     <= '0;
         a      <= '0;
         b      <= '0;
         target <= '0;
         aluout <= '0;
         mdr    <= '0;
      end else begin
         case (state_q)
            FETCH: begin
               if (memReady) begin
                  ir   <= memReadData;
                  pc_q <= pc_q + 32'd4;
               end
            end
            DECODE: begin
               a      <= rd1;
               b      <= rd2;
               target <= pc_q + {sext_imm[29:0], 2'b00};
               if (op == OP_J) pc_q <= {pc_q[31:28], ir[25:0], 2'b00};
            end
            EXECUTE: begin
               aluout <= alu_res;
               if ((op == OP_BEQ) && (a == b)) pc_q <= target;
            end
            MEMORY: begin
               if (memReady && (op == OP_LW)) mdr <= memReadData;
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from registered state only; reset gates the strobes so an
   // abandoned request drops immediately rather than at the next edge.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      memRead  = 1'b0;
      memWrite = 1'b0;
      memAddr  = pc_q[ADDR_WIDTH+1:2];
      case (state_q)
         FETCH: begin
            memRead = 1'b1;
            if (memReady) state_d = DECODE;
         end
         DECODE: begin
            if (!is_legal(op, funct)) state_d = HALT;
            else if (op == OP_J)      state_d = FETCH;
            else                      state_d = EXECUTE;
         end
         EXECUTE: begin
            if ((op == OP_LW) || (op == OP_SW)) state_d = MEMORY;
            else if (op == OP_BEQ)              state_d = FETCH;
            else                                state_d = WRITEBACK;
         end
         MEMORY: begin
            memAddr  = aluout[ADDR_WIDTH+1:2];
            memRead  = (op == OP_LW);
            memWrite = (op == OP_SW);
            if (memReady) state_d = (op == OP_LW) ? WRITEBACK : FETCH;
         end
         WRITEBACK: state_d = FETCH;
         HALT:      state_d = HALT;
         default:   state_d = FETCH;
      endcase
      if (reset) begin
         memRead  = 1'b0;
         memWrite = 1'b0;
      end
   end

   assign memWriteData = b;
   assign pc           = pc_q;
   assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with a unified word memory whose
// ready latency is set separately for the code and data regions.
module tb_multicycle_datapath;

   localparam int          AW        = 7;
   localparam int          DATA_BASE = 64;
   localparam logic [31:0] SPIN      = 32'h1000FFFF;
   localparam logic [31:0] FILL      = 32'hA5A5A5A5;

   logic           clk;
   logic           reset;
   logic [AW-1:0]  memAddr;
   logic [31:0]    memWriteData, memReadData, pc;
   logic           memRead, memWrite, memReady, halted;

   logic [31:0] mem      [128];
   logic [31:0] init_mem [128];
   int          fetch_lat, data_lat, lat, wait_cnt;
   int          n_checks, n_pass;

   multicycle_datapath #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .reset        (reset),
      .memAddr      (memAddr),
      .memWriteData (memWriteData),
      .memReadData  (memReadData),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .memReady     (memReady),
      .pc           (pc),
      .halted       (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign lat         = (int'(memAddr) >= DATA_BASE) ? data_lat : fetch_lat;
   assign memReady    = (memRead || memWrite) && (wait_cnt >= lat);
   assign memReadData = mem[memAddr];

   // Memory image is reloaded from init_mem whenever reset is high.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem      <= init_mem;
         wait_cnt <= 0;
      end else begin
         if ((memRead || memWrite) && !memReady) wait_cnt <= wait_cnt + 1;
         else                                    wait_cnt <= 0;
         if (memWrite && memReady) mem[memAddr] <= memWriteData;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'd0, funct};
   endfunction

   task automatic clear_image();
      for (int i = 0; i < 128; i++) init_mem[i] = (i >= DATA_BASE) ? FILL : 32'h0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic check_values);
      reset = 1'b1;
      step(2);
      if (check_values) begin
         check("rst_pc", pc, 32'h0);
         check("rst_memRead", {31'd0, memRead}, 32'd0);
         check("rst_memWrite", {31'd0, memWrite}, 32'd0);
         check("rst_memAddr", {25'd0, memAddr}, 32'd0);
         check("rst_memWriteData", memWriteData, 32'd0);
         check("rst_halted", {31'd0, halted}, 32'd0);
      end
      reset = 1'b0;
      #1;
      if (check_values) check("first_fetch_strobe", {31'd0, memRead}, 32'd1);
   endtask

   initial begin
      int budget;
      int strobes;
      reset    = 1'b1;
      n_checks = 0;
      n_pass   = 0;

      // addi then sw, zero-wait memory
      fetch_lat = 0; data_lat = 0;
      clear_image();
      init_mem[0] = 32'h20010005;
      init_mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0100);
      init_mem[2] = SPIN;
      do_reset(1'b1);
      step(1);
      check("addi_fetch_pc", pc, 32'h4);
      step(3);
      check("addi_4cyc_pc", pc, 32'h4);
      check("addi_next_fetch", {31'd0, memRead}, 32'd1);
      check("addi_next_addr", {25'd0, memAddr}, 32'd1);
      step(4);
      check("addi_result", mem[64], 32'd5);

      // ALU coverage with one wait cycle on fetch and two on data
      fetch_lat = 1; data_lat = 2;
      clear_image();
      init_mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);
      init_mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'h0002);
      init_mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h2A);
      init_mem[3]  = enc_r(5'd1, 5'd2, 5'd4, 6'h2B);
      init_mem[4]  = enc_r(5'd2, 5'd1, 5'd12, 6'h2B);
      init_mem[5]  = enc_r(5'd1, 5'd2, 5'd7, 6'h20);
      init_mem[6]  = enc_r(5'd1, 5'd2, 5'd8, 6'h22);
      init_mem[7]  = enc_r(5'd1, 5'd7, 5'd9, 6'h24);
      init_mem[8]  = enc_r(5'd1, 5'd2, 5'd10, 6'h25);
      init_mem[9]  = enc_r(5'd1, 5'd2, 5'd11, 6'h27);
      init_mem[10] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0100);
      init_mem[11] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0104);
      init_mem[12] = enc_i(6'h2B, 5'd0, 5'd12, 16'h0108);
      init_mem[13] = enc_i(6'h2B, 5'd0, 5'd7, 16'h010C);
      init_mem[14] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0110);
      init_mem[15] = enc_i(6'h2B, 5'd0, 5'd9, 16'h0114);
      init_mem[16] = enc_i(6'h2B, 5'd0, 5'd10, 16'h0118);
      init_mem[17] = enc_i(6'h2B, 5'd0, 5'd11, 16'h011C);
      init_mem[18] = SPIN;
      do_reset(1'b0);
      step(300);
      check("slt_signed", mem[64], 32'd1);
      check("sltu_neg_vs_pos", mem[65], 32'd0);
      check("sltu_pos_vs_neg", mem[66], 32'd1);
      check("add_wrap", mem[67], 32'hFFFFFFFF);
      check("sub", mem[68], 32'hFFFFFFFB);
      check("and", mem[69], 32'hFFFFFFFD);
      check("or", mem[70], 32'hFFFFFFFF);
      check("nor", mem[71], 32'h0);

      // sw/lw with three wait cycles on each data request
      fetch_lat = 0; data_lat = 3;
      clear_image();
      init_mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);
      init_mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0108);
      init_mem[2] = enc_i(6'h23, 5'd0, 5'd5, 16'h0108);
      init_mem[3] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0100);
      init_mem[4] = SPIN;
      do_reset(1'b0);
      step(7);
      for (int k = 0; k < 4; k++) begin
         check("sw_strobe", {31'd0, memWrite}, 32'd1);
         check("sw_no_read", {31'd0, memRead}, 32'd0);
         check("sw_data_stable", memWriteData, 32'hFFFFFFFD);
         check("sw_addr_stable", {25'd0, memAddr}, 32'd66);
         step(1);
      end
      check("sw_strobe_drop", {31'd0, memWrite}, 32'd0);
      check("sw_stored", mem[66], 32'hFFFFFFFD);
      step(3);
      check("lw_strobe", {31'd0, memRead}, 32'd1);
      check("lw_addr", {25'd0, memAddr}, 32'd66);
      step(4);
      check("lw_writeback_idle", {31'd0, memRead}, 32'd0);
      step(1);
      check("lw_8cyc_fetch", {31'd0, memRead}, 32'd1);
      check("lw_8cyc_addr", {25'd0, memAddr}, 32'd3);
      check("lw_8cyc_pc", pc, 32'hC);
      step(12);
      check("lw_value", mem[64], 32'hFFFFFFFD);

      // jumps and a taken branch loop
      fetch_lat = 0; data_lat = 0;
      clear_image();
      init_mem[0]  = 32'h08000010;
      init_mem[16] = 32'h08000004;
      init_mem[4]  = SPIN;
      do_reset(1'b0);
      step(1);
      check("j_fetch_pc", pc, 32'h4);
      step(1);
      check("j_target", pc, 32'h40);
      step(2);
      check("j_back", pc, 32'h10);
      step(1);
      check("beq_fetch_pc", pc, 32'h14);
      step(2);
      check("beq_loop1", pc, 32'h10);
      step(3);
      check("beq_loop2", pc, 32'h10);

      // $0 immutability, branch not-taken / taken, then illegal opcode halt
      clear_image();
      init_mem[0] = 32'h20000007;
      init_mem[1] = enc_r(5'd0, 5'd0, 5'd6, 6'h20);
      init_mem[2] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      init_mem[3] = enc_i(6'h04, 5'd1, 5'd0, 16'd1);
      init_mem[4] = enc_i(6'h08, 5'd0, 5'd13, 16'd9);
      init_mem[5] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0100);
      init_mem[6] = enc_i(6'h2B, 5'd0, 5'd13, 16'h0104);
      init_mem[7] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
      init_mem[8] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0108);
      init_mem[9] = 32'hFC000000;
      do_reset(1'b0);
      budget = 200;
      while (!halted && budget > 0) begin
         step(1);
         budget--;
      end
      check("halt_reached", {31'd0, halted}, 32'd1);
      check("r0_discarded", mem[64], 32'h0);
      check("beq_not_taken", mem[65], 32'd9);
      check("beq_taken_skip", mem[66], FILL);
      check("halt_pc", pc, 32'h28);
      strobes = 0;
      for (int k = 0; k < 20; k++) begin
         if (memRead || memWrite) strobes++;
         step(1);
      end
      check("halt_no_strobes", strobes, 32'd0);
      check("halt_sticky", {31'd0, halted}, 32'd1);

      // unsupported R-type funct halts from DECODE
      clear_image();
      init_mem[0] = 32'h00000021;
      do_reset(1'b0);
      step(1);
      check("funct_decode_not_halted", {31'd0, halted}, 32'd0);
      step(1);
      check("funct_illegal_halt", {31'd0, halted}, 32'd1);

      // reset asserted while a load is waiting on memory
      fetch_lat = 0; data_lat = 5;
      clear_image();
      init_mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      init_mem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h0100);
      init_mem[2] = SPIN;
      do_reset(1'b0);
      step(7);
      check("midlw_strobe", {31'd0, memRead}, 32'd1);
      check("midlw_addr", {25'd0, memAddr}, 32'd64);
      step(1);
      #2;
      reset = 1'b1;
      #1;
      check("midlw_strobe_drop", {31'd0, memRead}, 32'd0);
      check("midlw_pc", pc, 32'h0);
      check("midlw_addr_reset", {25'd0, memAddr}, 32'd0);
      clear_image();
      init_mem[0] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0104);
      init_mem[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0100);
      init_mem[2] = SPIN;
      data_lat = 0;
      step(2);
      reset = 1'b0;
      #1;
      check("midlw_refetch", {31'd0, memRead}, 32'd1);
      step(20);
      check("midlw_r1_cleared", mem[65], 32'h0);
      check("midlw_r2_cleared", mem[64], 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
